// File: rtl/deserializer_pkg.sv
// Shared definitions for the serial-to-parallel deserializer:
// default sizes, the mod/bit-count width helper and the FSM state type.
package deserializer_pkg;

  localparam int DESER_DATA_W_DEFAULT   = 16;
  localparam int DESER_IDLE_GAP_DEFAULT = 4;

  // Width of the bit count / mod field: enough to hold 0..DATA_W-1.
  function automatic int deser_mod_w(input int data_w);
    return (data_w <= 2) ? 1 : $clog2(data_w);
  endfunction

  // IDLE: no bits of the current word held; COLLECT: 1..DATA_W-1 bits held.
  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } deser_state_e;

endpackage

// File: rtl/deser_gap_timer.sv
// Idle-gap timer for the deserializer flush feature (DESERIALIZER_FLUSH_EN).
// Counts idle cycles while a partial word is held and flags when IDLE_GAP
// idle cycles have elapsed. Saturates at IDLE_GAP until cleared.
module deser_gap_timer
  import deserializer_pkg::*;
#(
  parameter int IDLE_GAP = DESER_IDLE_GAP_DEFAULT
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int GAP_W = (IDLE_GAP < 1) ? 1 : $clog2(IDLE_GAP + 1);

  logic [GAP_W-1:0] r_gap;

  // Clear has priority; otherwise count idle cycles up to the limit.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_gap <= '0;
    end else if (clr_i) begin
      r_gap <= '0;
    end else if (inc_i && !expired_o) begin
      r_gap <= r_gap + 1'b1;
    end
  end

  assign expired_o = (r_gap == GAP_W'(IDLE_GAP));

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel deserializer, MSB first. Valid bits are placed directly
// at their final (left-aligned) position, so a flushed partial word already
// has its unused LSBs at zero. A complete word is registered onto the output
// together with a one-cycle valid pulse; outputs hold between pulses.
// Optional feature: define DESERIALIZER_FLUSH_EN to flush a partial word
// after IDLE_GAP idle cycles, reporting the number of valid MSBs on deser_mod_o.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int DATA_W   = DESER_DATA_W_DEFAULT,
  parameter int IDLE_GAP = DESER_IDLE_GAP_DEFAULT
) (
  input  logic                           clk_i,
  input  logic                           arstn_i,
  input  logic                           data_i,
  input  logic                           data_val_i,
  output logic [DATA_W-1:0]              deser_data_o,
  output logic [deser_mod_w(DATA_W)-1:0] deser_mod_o,
  output logic                           deser_data_val_o,
  output logic                           busy_o
);

  localparam int CNT_W = deser_mod_w(DATA_W);

  deser_state_e      r_state;
  deser_state_e      w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [CNT_W-1:0]  w_idx;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_next;
  logic              r_val;
  logic              w_val_next;
  logic              r_busy;
  logic              w_full;
  logic              w_flush;

  // Bit position (from the LSB) where the next valid bit lands.
  assign w_idx = CNT_W'(DATA_W - 1) - r_cnt;

  // Next-state and datapath: append a valid bit, emit on the last bit,
  // or emit the partial word when the gap timer asks for a flush.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shift_next = r_shift;
    w_data_next  = r_data;
    w_val_next   = 1'b0;
    w_full       = 1'b0;
    // A new word starts from zero so stale bits never leak into it.
    w_word       = (r_state == IDLE) ? '0 : r_shift;
    w_word[w_idx] = data_i;

    if (data_val_i) begin
      if (r_cnt == CNT_W'(DATA_W - 1)) begin
        w_full       = 1'b1;
        w_data_next  = w_word;
        w_val_next   = 1'b1;
        w_cnt_next   = '0;
        w_shift_next = '0;
        w_state_next = IDLE;
      end else begin
        w_cnt_next   = r_cnt + 1'b1;
        w_shift_next = w_word;
        w_state_next = COLLECT;
      end
    end else if (w_flush) begin
      w_data_next  = r_shift;
      w_val_next   = 1'b1;
      w_cnt_next   = '0;
      w_shift_next = '0;
      w_state_next = IDLE;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_val   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_shift <= w_shift_next;
      r_data  <= w_data_next;
      r_val   <= w_val_next;
      r_busy  <= (w_cnt_next != '0);
    end
  end

`ifdef DESERIALIZER_FLUSH_EN
  logic             w_gap_expired;
  logic [CNT_W-1:0] r_mod;

  deser_gap_timer #(
    .IDLE_GAP (IDLE_GAP)
  ) u_gap_timer (
    .clk_i     (clk_i),
    .arstn_i   (arstn_i),
    .inc_i     ((r_state == COLLECT) && !data_val_i),
    .clr_i     (data_val_i || w_flush),
    .expired_o (w_gap_expired)
  );

  // A valid bit in the expiry cycle wins: it is appended instead of flushing.
  assign w_flush = w_gap_expired && !data_val_i && (r_state == COLLECT);

  // Mod holds the bit count of a flushed word, 0 for a full word.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_mod <= '0;
    end else if (w_flush) begin
      r_mod <= r_cnt;
    end else if (w_full) begin
      r_mod <= '0;
    end
  end

  assign deser_mod_o = r_mod;
`else
  logic w_unused_gap;

  assign w_flush      = 1'b0;
  assign deser_mod_o  = '0;
  assign w_unused_gap = (IDLE_GAP != 0) || w_full;
`endif

  assign deser_data_o     = r_data;
  assign deser_data_val_o = r_val;
  assign busy_o           = r_busy;

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for the deserializer. The driver feeds bits and a
// queue-based reference model pushes expected words (with the clock edge at
// which they must appear); an independent monitor pops and compares.
// Flush behaviour is modelled when DESERIALIZER_FLUSH_EN is defined.
module tb_deserializer;

  localparam int DW  = 16;
  localparam int GAP = 4;

  logic          clk = 1'b0;
  logic          arstn_i;
  logic          data_i;
  logic          data_val_i;
  logic [DW-1:0] deser_data_o;
  logic [3:0]    deser_mod_o;
  logic          deser_data_val_o;
  logic          busy_o;

  deserializer #(
    .DATA_W   (DW),
    .IDLE_GAP (GAP)
  ) dut (
    .clk_i            (clk),
    .arstn_i          (arstn_i),
    .data_i           (data_i),
    .data_val_i       (data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_mod_o      (deser_mod_o),
    .deser_data_val_o (deser_data_val_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            edge_n;
    logic [DW-1:0] data;
    logic [3:0]    mod;
  } exp_t;

  exp_t          sb[$];
  bit            exp_busy[int];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            n_words = 0;
  logic [DW-1:0] last_data = '0;
  logic [3:0]    last_mod = '0;

  // Reference model state: bits of the word in progress and idle run length.
  bit model_bits[$];
  int model_gap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] pack_bits(input bit b[$]);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < b.size(); i++) w[DW-1-i] = b[i];
    return w;
  endfunction

  // Drive one cycle of input and advance the model to the edge that samples it.
  task automatic send_bit(input bit v, input bit d);
    int   e;
    exp_t x;
    @(posedge clk);
    #1;
    data_val_i = v;
    data_i     = d;
    e = cyc + 1;
    if (v) begin
      model_bits.push_back(d);
      model_gap = 0;
      if (model_bits.size() == DW) begin
        x.edge_n = e; x.data = pack_bits(model_bits); x.mod = 4'd0;
        sb.push_back(x);
        model_bits.delete();
      end
    end else if (model_bits.size() > 0) begin
`ifdef DESERIALIZER_FLUSH_EN
      if (model_gap == GAP) begin
        x.edge_n = e; x.data = pack_bits(model_bits); x.mod = 4'(model_bits.size());
        sb.push_back(x);
        model_bits.delete();
        model_gap = 0;
      end else begin
        model_gap++;
      end
`endif
    end
    exp_busy[e] = (model_bits.size() != 0);
  endtask

  task automatic send_word(input logic [DW-1:0] w, input bit gaps);
    for (int i = DW - 1; i >= 0; i--) begin
      send_bit(1'b1, w[i]);
      if (gaps) send_bit(1'b0, 1'b0);
    end
  endtask

  // One-cycle asynchronous reset; outputs must clear without a clock edge.
  task automatic pulse_reset();
    @(posedge clk);
    #1;
    data_val_i = 1'b0;
    arstn_i    = 1'b0;
    model_bits.delete();
    model_gap = 0;
    sb.delete();
    exp_busy.delete(cyc);
    last_data = '0;
    last_mod  = '0;
    #1;
    chk("rst_async_data", 32'(deser_data_o), 32'h0);
    chk("rst_async_mod", 32'(deser_mod_o), 32'h0);
    chk("rst_async_val", 32'(deser_data_val_o), 32'h0);
    chk("rst_async_busy", 32'(busy_o), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_busy_held", 32'(busy_o), 32'h0);
    arstn_i = 1'b1;
  endtask

  // Monitor: compare every pulse against the scoreboard, and check outputs
  // hold and busy tracks the model between pulses.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].edge_n < cyc) begin
      chk("missed_pulse_edge", 32'(cyc), 32'(sb[0].edge_n));
      void'(sb.pop_front());
    end
    if (deser_data_val_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'h1, 32'h0);
      end else begin
        chk("pulse_edge", 32'(cyc), 32'(sb[0].edge_n));
        chk("word_data", 32'(deser_data_o), 32'(sb[0].data));
        chk("word_mod", 32'(deser_mod_o), 32'(sb[0].mod));
        last_data = sb[0].data;
        last_mod  = sb[0].mod;
        n_words++;
        void'(sb.pop_front());
      end
    end else begin
      chk("hold_data", 32'(deser_data_o), 32'(last_data));
      chk("hold_mod", 32'(deser_mod_o), 32'(last_mod));
    end
    if (exp_busy.exists(cyc)) begin
      chk("busy", 32'(busy_o), 32'(exp_busy[cyc]));
      exp_busy.delete(cyc);
    end
  end

  initial begin
    bit b[5];
    b = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    arstn_i    = 1'b0;
    data_i     = 1'b0;
    data_val_i = 1'b0;
    #2;
    chk("reset_data", 32'(deser_data_o), 32'h0);
    chk("reset_mod", 32'(deser_mod_o), 32'h0);
    chk("reset_val", 32'(deser_data_val_o), 32'h0);
    chk("reset_busy", 32'(busy_o), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    arstn_i = 1'b1;

    // Contiguous word, then the same word with idle cycles interleaved.
    send_word(16'hA5C3, 1'b0);
    send_word(16'hA5C3, 1'b1);
    // Two words back-to-back: pulses 16 edges apart.
    send_word(16'h0001, 1'b0);
    send_word(16'hFFFE, 1'b0);
    repeat (3) send_bit(1'b0, 1'b0);

    // Reset mid-word discards the partial word.
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'($urandom_range(0, 1)));
    pulse_reset();
    send_word(16'h1234, 1'b0);
    repeat (2) send_bit(1'b0, 1'b0);

    // Five bits then a long idle run (flushes as 16'hB000 / mod 5 when enabled).
    for (int i = 0; i < 5; i++) send_bit(1'b1, b[i]);
    repeat (8) send_bit(1'b0, 1'b0);
    pulse_reset();

    // Five bits, three idle cycles, a valid bit on the fourth, then ten more.
    for (int i = 0; i < 5; i++) send_bit(1'b1, b[i]);
    repeat (3) send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    #2;
    chk("busy_after_cancel", 32'(busy_o), 32'h1);
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'($urandom_range(0, 1)));
    repeat (2) send_bit(1'b0, 1'b0);

    // Random traffic with occasional long idle runs.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        repeat ($urandom_range(3, 7)) send_bit(1'b0, 1'b0);
      end else begin
        send_bit($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      end
    end
    repeat (8) send_bit(1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    if (n_words < 20) chk("enough_words", 32'(n_words), 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish (edge %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
